vid_pixel_pal: RTL and testbench

Parametrised successor to the BK-0010 video back end. It combines three functions:
- a loadable pixel shifter with 1, 2 or 4 bits per pixel;
- a programmable palette RAM with a bus-writable control register, replacing the fixed palette ROM;
- a frame-interrupt generator with enable, divider and acknowledge.

It sits between the DRAM data latch / PLA timing (load strobe, vsync) and the RGB/mono video outputs, and drives the CPU radial IRQ line.

---
 rtl/vid_pkg.sv | 14 +
 rtl/vid_frame_irq.sv | 63 ++++++
 rtl/vid_pixel_pal.sv | 128 ++++++++++++
 tb/tb_vid_pixel_pal.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared register layout, bus addresses and handshake states for the
// pixel/palette/interrupt video back end.
package vid_pkg;

    localparam int PAL_SEL_LSB = 8;
    localparam int IRQ_EN_BIT  = 14;
    localparam int IDX_LSB     = 8;

    localparam logic REG_CTRL = 1'b0;
    localparam logic REG_PAL  = 1'b1;

    typedef enum logic {IDLE, ACK} hs_state_e;

endpackage

// File: rtl/vid_frame_irq.sv
// Frame interrupt generator: vsync_n falling-edge detector, frame divider
// counter and a pending flag presented as a registered active-low IRQ.
module vid_frame_irq
    import vid_pkg::*;
#(
    parameter int FRAME_DIV = 1
) (
    input  logic pin_clk,
    input  logic pin_rst_n,
    input  logic irq_en,
    input  logic en_clear,
    input  logic vsync_n,
    input  logic irq_ack,
    output logic irq_n
);

    localparam logic [7:0] LAST_CNT = 8'(FRAME_DIV - 1);

    logic       vsync_prev_q, vsync_prev_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pending_q, pending_d;
    logic       irq_n_q, irq_n_d;
    logic       frame_evt;

    always_comb begin
        frame_evt    = vsync_prev_q & ~vsync_n;
        vsync_prev_d = vsync_n;
        irq_n_d      = ~pending_q;

        cnt_d = cnt_q;
        if (en_clear) begin
            cnt_d = 8'd0;
        end else if (frame_evt) begin
            cnt_d = (cnt_q == LAST_CNT) ? 8'd0 : cnt_q + 8'd1;
        end

        // A qualifying frame event overrides a simultaneous acknowledge.
        pending_d = pending_q;
        if (irq_ack || en_clear) begin
            pending_d = 1'b0;
        end
        if (frame_evt && (cnt_q == LAST_CNT) && irq_en) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            vsync_prev_q <= 1'b1;
            cnt_q        <= 8'd0;
            pending_q    <= 1'b0;
            irq_n_q      <= 1'b1;
        end else begin
            vsync_prev_q <= vsync_prev_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            irq_n_q      <= irq_n_d;
        end
    end

    assign irq_n = irq_n_q;

endmodule

// File: rtl/vid_pixel_pal.sv
// Video back end: loadable pixel shifter, flop-based programmable palette with
// a write-handshaked control register, and the frame interrupt generator.
module vid_pixel_pal
    import vid_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int BPP       = 2,
    parameter int PAL_BITS  = 4,
    parameter int COLOR_W   = 4,
    parameter int FRAME_DIV = 1
) (
    input  logic               pin_clk,
    input  logic               pin_rst_n,
    input  logic               load,
    input  logic [WORD_W-1:0]  vdata,
    input  logic               vsync_n,
    input  logic               reg_wr,
    input  logic               reg_addr,
    input  logic [15:0]        reg_wdata,
    output logic               reg_rply,
    input  logic               irq_ack,
    output logic [COLOR_W-1:0] rgb,
    output logic               mono,
    output logic               irq_n
);

    localparam int IDX_W    = PAL_BITS + BPP;
    localparam int N_ENT    = 1 << IDX_W;
    localparam int PIX_MASK = (1 << BPP) - 1;

    logic [WORD_W-1:0]   sh_q, sh_d;
    logic [BPP-1:0]      pix;
    logic [COLOR_W-1:0]  pal_q [N_ENT];
    logic [COLOR_W-1:0]  pal_d [N_ENT];
    logic [PAL_BITS-1:0] pal_sel_q, pal_sel_d;
    logic                irq_en_q, irq_en_d;
    hs_state_e           state_q, state_d;
    logic [COLOR_W-1:0]  rgb_q, rgb_d;
    logic                mono_q, mono_d;
    logic                wr_fire;
    logic                en_clear;
    logic [IDX_W-1:0]    wr_idx;
    logic                unused_wdata;

    assign pix          = sh_q[BPP-1:0];
    assign wr_idx       = reg_wdata[IDX_LSB +: IDX_W];
    assign unused_wdata = ^reg_wdata;

    always_comb begin
        sh_d = load ? vdata : {{BPP{1'b1}}, sh_q[WORD_W-1:BPP]};

        // The register write happens only on the IDLE->ACK transition, so a
        // long strobe still produces exactly one write.
        state_d = state_q;
        wr_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (reg_wr) begin
                    state_d = ACK;
                    wr_fire = 1'b1;
                end
            end
            ACK: begin
                if (!reg_wr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pal_sel_d = pal_sel_q;
        irq_en_d  = irq_en_q;
        en_clear  = 1'b0;
        if (wr_fire && (reg_addr == REG_CTRL)) begin
            pal_sel_d = reg_wdata[PAL_SEL_LSB +: PAL_BITS];
            irq_en_d  = reg_wdata[IRQ_EN_BIT];
            en_clear  = ~reg_wdata[IRQ_EN_BIT];
        end

        pal_d = pal_q;
        if (wr_fire && (reg_addr == REG_PAL)) begin
            pal_d[wr_idx] = reg_wdata[COLOR_W-1:0];
        end

        rgb_d  = pal_q[{pal_sel_q, pix}];
        mono_d = |pix;
    end

    // Each palette entry powers up holding its own pixel code.
    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            sh_q      <= '1;
            pal_sel_q <= '1;
            irq_en_q  <= 1'b1;
            state_q   <= IDLE;
            rgb_q     <= '0;
            mono_q    <= 1'b0;
            for (int i = 0; i < N_ENT; i++) begin
                pal_q[i] <= COLOR_W'(i & PIX_MASK);
            end
        end else begin
            sh_q      <= sh_d;
            pal_sel_q <= pal_sel_d;
            irq_en_q  <= irq_en_d;
            state_q   <= state_d;
            rgb_q     <= rgb_d;
            mono_q    <= mono_d;
            pal_q     <= pal_d;
        end
    end

    assign reg_rply = (state_q == ACK);
    assign rgb      = rgb_q;
    assign mono     = mono_q;

    vid_frame_irq #(
        .FRAME_DIV (FRAME_DIV)
    ) u_frame_irq (
        .pin_clk   (pin_clk),
        .pin_rst_n (pin_rst_n),
        .irq_en    (irq_en_q),
        .en_clear  (en_clear),
        .vsync_n   (vsync_n),
        .irq_ack   (irq_ack),
        .irq_n     (irq_n)
    );

endmodule

// File: tb/tb_vid_pixel_pal.sv
// Directed bench: instance A (BPP=2, FRAME_DIV=2) covers shifter, palette,
// handshake and interrupts; instance B (BPP=4) covers the wide-pixel shifter.
module tb_vid_pixel_pal;

    logic        pin_clk;
    logic        pin_rst_n;

    logic        a_load, a_vsync_n, a_reg_wr, a_reg_addr, a_irq_ack;
    logic [15:0] a_vdata, a_reg_wdata;
    logic        a_reg_rply, a_mono, a_irq_n;
    logic [3:0]  a_rgb;

    logic        b_load, b_vsync_n, b_reg_wr, b_reg_addr, b_irq_ack;
    logic [15:0] b_vdata, b_reg_wdata;
    logic        b_reg_rply, b_mono, b_irq_n;
    logic [3:0]  b_rgb;

    int vectors;
    int miscompares;

    vid_pixel_pal #(
        .WORD_W(16), .BPP(2), .PAL_BITS(4), .COLOR_W(4), .FRAME_DIV(2)
    ) u_a (
        .pin_clk   (pin_clk),
        .pin_rst_n (pin_rst_n),
        .load      (a_load),
        .vdata     (a_vdata),
        .vsync_n   (a_vsync_n),
        .reg_wr    (a_reg_wr),
        .reg_addr  (a_reg_addr),
        .reg_wdata (a_reg_wdata),
        .reg_rply  (a_reg_rply),
        .irq_ack   (a_irq_ack),
        .rgb       (a_rgb),
        .mono      (a_mono),
        .irq_n     (a_irq_n)
    );

    vid_pixel_pal #(
        .WORD_W(16), .BPP(4), .PAL_BITS(4), .COLOR_W(4), .FRAME_DIV(1)
    ) u_b (
        .pin_clk   (pin_clk),
        .pin_rst_n (pin_rst_n),
        .load      (b_load),
        .vdata     (b_vdata),
        .vsync_n   (b_vsync_n),
        .reg_wr    (b_reg_wr),
        .reg_addr  (b_reg_addr),
        .reg_wdata (b_reg_wdata),
        .reg_rply  (b_reg_rply),
        .irq_ack   (b_irq_ack),
        .rgb       (b_rgb),
        .mono      (b_mono),
        .irq_n     (b_irq_n)
    );

    initial pin_clk = 1'b0;
    always #5 pin_clk = ~pin_clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        pin_rst_n   = 1'b0;
        a_load = 1'b0; a_vdata = 16'h0; a_vsync_n = 1'b1; a_reg_wr = 1'b0;
        a_reg_addr = 1'b0; a_reg_wdata = 16'h0; a_irq_ack = 1'b0;
        b_load = 1'b0; b_vdata = 16'h0; b_vsync_n = 1'b1; b_reg_wr = 1'b0;
        b_reg_addr = 1'b0; b_reg_wdata = 16'h0; b_irq_ack = 1'b0;
        repeat (2) @(negedge pin_clk);
        vectors++;
        if (a_rgb !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_rgb: got %0h expected 0", a_rgb);
        end
        vectors++;
        if (a_mono !== 1'b0 || a_irq_n !== 1'b1 || a_reg_rply !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctl: mono=%b irq_n=%b rply=%b expected 0 1 0",
                     a_mono, a_irq_n, a_reg_rply);
        end
        vectors++;
        if (b_rgb !== 4'h0 || b_irq_n !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_b: rgb=%0h irq_n=%b expected 0 1", b_rgb, b_irq_n);
        end
        pin_rst_n = 1'b1;
        @(negedge pin_clk);
        vectors++;
        if (a_rgb !== 4'h3 || a_mono !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_fill_a: rgb=%0h mono=%b expected 3 1", a_rgb, a_mono);
        end
        vectors++;
        if (b_rgb !== 4'hF) begin
            miscompares++;
            $display("[TB] FAIL reset_fill_b: rgb=%0h expected f", b_rgb);
        end
    endtask

    task automatic test_shift_default();
        logic [3:0] exp_rgb [9];
        exp_rgb = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 4'h1, 4'h2, 4'h3, 4'h3};
        a_load  = 1'b1;
        a_vdata = 16'hE4E4;
        @(negedge pin_clk);
        a_load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge pin_clk);
            vectors++;
            if (a_rgb !== exp_rgb[i]) begin
                miscompares++;
                $display("[TB] FAIL shift_rgb[%0d]: got %0h expected %0h", i, a_rgb, exp_rgb[i]);
            end
            vectors++;
            if (a_mono !== (exp_rgb[i] != 4'h0)) begin
                miscompares++;
                $display("[TB] FAIL shift_mono[%0d]: got %b expected %b", i, a_mono,
                         (exp_rgb[i] != 4'h0));
            end
        end
    endtask

    task automatic test_palette_write();
        a_reg_addr  = 1'b0;
        a_reg_wdata = 16'h0200;
        a_reg_wr    = 1'b1;
        #1;
        vectors++;
        if (a_reg_rply !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rply_early: got %b expected 0", a_reg_rply);
        end
        @(negedge pin_clk);
        vectors++;
        if (a_reg_rply !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rply_rise: got %b expected 1", a_reg_rply);
        end
        a_reg_wr = 1'b0;
        @(negedge pin_clk);
        vectors++;
        if (a_reg_rply !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rply_fall: got %b expected 0", a_reg_rply);
        end
        a_reg_addr  = 1'b1;
        a_reg_wdata = 16'h090A;
        a_reg_wr    = 1'b1;
        @(negedge pin_clk);
        a_reg_wr = 1'b0;
        @(negedge pin_clk);
        a_load  = 1'b1;
        a_vdata = 16'h0001;
        @(negedge pin_clk);
        a_load = 1'b0;
        @(negedge pin_clk);
        vectors++;
        if (a_rgb !== 4'hA || a_mono !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pal_entry: rgb=%0h mono=%b expected a 1", a_rgb, a_mono);
        end
        @(negedge pin_clk);
        vectors++;
        if (a_rgb !== 4'h0 || a_mono !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL pal_sel2_pix0: rgb=%0h mono=%b expected 0 0", a_rgb, a_mono);
        end
    endtask

    task automatic test_long_strobe();
        a_reg_addr  = 1'b1;
        a_reg_wdata = 16'h0905;
        a_reg_wr    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge pin_clk);
            vectors++;
            if (a_reg_rply !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL strobe_rply[%0d]: got %b expected 1", i, a_reg_rply);
            end
            a_reg_wdata = a_reg_wdata + 16'h1;
        end
        a_reg_wr = 1'b0;
        @(negedge pin_clk);
        vectors++;
        if (a_reg_rply !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL strobe_rply_end: got %b expected 0", a_reg_rply);
        end
        a_load  = 1'b1;
        a_vdata = 16'h0001;
        @(negedge pin_clk);
        a_load = 1'b0;
        @(negedge pin_clk);
        vectors++;
        if (a_rgb !== 4'h5) begin
            miscompares++;
            $display("[TB] FAIL strobe_single_write: rgb=%0h expected 5", a_rgb);
        end
    endtask

    task automatic test_frame_irq();
        a_reg_addr  = 1'b0;
        a_reg_wdata = 16'h4F00;
        a_reg_wr    = 1'b1;
        @(negedge pin_clk);
        a_reg_wr = 1'b0;
        @(negedge pin_clk);
        // frame 1: counter 0 -> 1, no request
        a_vsync_n = 1'b0;
        @(negedge pin_clk);
        a_vsync_n = 1'b1;
        @(negedge pin_clk);
        vectors++;
        if (a_irq_n !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL irq_frame1: got %b expected 1", a_irq_n);
        end
        // frame 2: request, visible one edge after the sampling edge
        a_vsync_n = 1'b0;
        @(negedge pin_clk);
        vectors++;
        if (a_irq_n !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL irq_latency: got %b expected 1", a_irq_n);
        end
        a_vsync_n = 1'b1;
        @(negedge pin_clk);
        vectors++;
        if (a_irq_n !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL irq_frame2: got %b expected 0", a_irq_n);
        end
        a_irq_ack = 1'b1;
        @(negedge pin_clk);
        a_irq_ack = 1'b0;
        @(negedge pin_clk);
        vectors++;
        if (a_irq_n !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL irq_ack_clear: got %b expected 1", a_irq_n);
        end
        a_vsync_n = 1'b0;
        @(negedge pin_clk);
        a_vsync_n = 1'b1;
        @(negedge pin_clk);
        vectors++;
        if (a_irq_n !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL irq_frame3: got %b expected 1", a_irq_n);
        end
        a_vsync_n = 1'b0;
        a_irq_ack = 1'b1;
        @(negedge pin_clk);
        a_vsync_n = 1'b1;
        a_irq_ack = 1'b0;
        @(negedge pin_clk);
        vectors++;
        if (a_irq_n !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL irq_set_wins: got %b expected 0", a_irq_n);
        end
    endtask

    task automatic test_irq_disable();
        a_reg_addr  = 1'b0;
        a_reg_wdata = 16'h0F00;
        a_reg_wr    = 1'b1;
        @(negedge pin_clk);
        a_reg_wr = 1'b0;
        @(negedge pin_clk);
        vectors++;
        if (a_irq_n !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL irq_disable_clear: got %b expected 1", a_irq_n);
        end
        for (int i = 0; i < 4; i++) begin
            a_vsync_n = 1'b0;
            @(negedge pin_clk);
            a_vsync_n = 1'b1;
            repeat (2) @(negedge pin_clk);
            vectors++;
            if (a_irq_n !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL irq_disabled[%0d]: got %b expected 1", i, a_irq_n);
            end
        end
    endtask

    task automatic test_bpp4();
        logic [3:0] exp_full [5];
        logic       ld_seq   [8];
        logic [3:0] exp_mid  [8];
        exp_full = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF};
        ld_seq   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_mid  = '{4'h1, 4'h2, 4'h3, 4'h7, 4'h8, 4'h9, 4'hA, 4'hF};
        b_load  = 1'b1;
        b_vdata = 16'h4321;
        @(negedge pin_clk);
        b_load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge pin_clk);
            vectors++;
            if (b_rgb !== exp_full[i] || b_mono !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL bpp4_pix[%0d]: rgb=%0h mono=%b expected %0h 1",
                         i, b_rgb, b_mono, exp_full[i]);
            end
        end
        b_load  = 1'b1;
        b_vdata = 16'h4321;
        @(negedge pin_clk);
        for (int i = 0; i < 8; i++) begin
            b_load  = ld_seq[i];
            b_vdata = 16'hA987;
            @(negedge pin_clk);
            vectors++;
            if (b_rgb !== exp_mid[i]) begin
                miscompares++;
                $display("[TB] FAIL bpp4_reload[%0d]: rgb=%0h expected %0h", i, b_rgb, exp_mid[i]);
            end
        end
        b_load = 1'b0;
    endtask

    task automatic test_reset_mid_handshake();
        a_reg_addr  = 1'b0;
        a_reg_wdata = 16'h4300;
        a_reg_wr    = 1'b1;
        @(negedge pin_clk);
        vectors++;
        if (a_reg_rply !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midhs_rply_high: got %b expected 1", a_reg_rply);
        end
        #2;
        pin_rst_n = 1'b0;
        #1;
        vectors++;
        if (a_reg_rply !== 1'b0 || a_rgb !== 4'h0 || a_irq_n !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midhs_reset: rply=%b rgb=%0h irq_n=%b expected 0 0 1",
                     a_reg_rply, a_rgb, a_irq_n);
        end
        a_reg_wr = 1'b0;
        @(negedge pin_clk);
        pin_rst_n = 1'b1;
        @(negedge pin_clk);
        vectors++;
        if (a_reg_rply !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midhs_after: rply=%b expected 0", a_reg_rply);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_shift_default();
        test_palette_write();
        test_long_strobe();
        test_frame_irq();
        test_irq_disable();
        test_bpp4();
        test_reset_mid_handshake();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
